// File: rtl/logic_pod_ram_writer.sv
// Drains one address plus two 256-bit data words per burst from the pod FIFOs
// and issues them as a single DRAM write command with a two-beat data burst.
module logic_pod_ram_writer #(
    parameter int STALL_LIMIT = 1023
) (
    input  logic         clk_ram,
    input  logic         rst_n,
    input  logic         addr_fifo_empty,
    output logic         addr_fifo_rd_en,
    input  logic [28:0]  addr_fifo_rd_data,
    input  logic [8:0]   data_fifo_rd_size,
    output logic         data_fifo_rd_en,
    input  logic [255:0] data_fifo_rd_data,
    output logic         app_en,
    output logic [2:0]   app_cmd,
    output logic [28:0]  app_addr,
    input  logic         app_rdy,
    output logic         app_wdf_wren,
    output logic [255:0] app_wdf_data,
    output logic         app_wdf_end,
    output logic [31:0]  app_wdf_mask,
    input  logic         app_wdf_rdy,
    output logic         idle,
    output logic [31:0]  burst_count,
    output logic         stall_err
);
    localparam int DATA_W = 256;
    localparam int CW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

    typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, ISSUE} state_t;

    state_t            state;
    logic [DATA_W-1:0] beat1;
    logic [CW-1:0]     stall_cnt;
    logic              can_start;
    logic              burst_done;

    // A burst only starts when both the address and both data words are present.
    always_comb begin
        can_start  = !addr_fifo_empty && (data_fifo_rd_size >= 9'd2);
        burst_done = (!app_en || app_rdy) && app_wdf_end && (!app_wdf_wren || app_wdf_rdy);
    end

    assign addr_fifo_rd_en = rst_n && (state == IDLE) && can_start;
    assign data_fifo_rd_en = rst_n && (((state == IDLE) && can_start) || (state == FETCH0));
    assign idle            = (state == IDLE);
    assign app_cmd         = 3'b000;
    assign app_wdf_mask    = 32'd0;

    always_ff @(posedge clk_ram or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            app_en       <= 1'b0;
            app_addr     <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_end  <= 1'b0;
            burst_count  <= '0;
            stall_err    <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_start) state <= FETCH0;
                end
                FETCH0: begin
                    // Beat 0 is parked directly in the output data register.
                    app_addr     <= addr_fifo_rd_data;
                    app_wdf_data <= data_fifo_rd_data;
                    state        <= FETCH1;
                end
                FETCH1: begin
                    app_en       <= 1'b1;
                    app_wdf_wren <= 1'b1;
                    app_wdf_end  <= 1'b0;
                    stall_cnt    <= '0;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    if (app_en && app_rdy) app_en <= 1'b0;
                    if (app_wdf_wren && app_wdf_rdy) begin
                        if (!app_wdf_end) begin
                            app_wdf_data <= beat1;
                            app_wdf_end  <= 1'b1;
                        end else begin
                            app_wdf_wren <= 1'b0;
                        end
                    end
                    if (burst_done) begin
                        state        <= IDLE;
                        app_wdf_wren <= 1'b0;
                        app_wdf_end  <= 1'b0;
                        burst_count  <= burst_count + 32'd1;
                    end else if (stall_cnt != LIMIT) begin
                        stall_cnt <= stall_cnt + 1'b1;
                        if (stall_cnt + 1'b1 == LIMIT) stall_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat 1 holding register carries no reset; it is always loaded before use.
    always_ff @(posedge clk_ram) begin
        if (state == FETCH1) beat1 <= data_fifo_rd_data;
    end

endmodule

// File: doc/logic_pod_ram_writer.md
LOGIC_POD_RAM_WRITER -- requirements
Module: logic_pod_ram_writer

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 1023: ISSUE-state cycles without completion before stall_err asserts.
REQ-002 SHALL have port clk_ram  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr_fifo_empty  input  1  address FIFO holds no entry.
REQ-005 SHALL have port addr_fifo_rd_en  output  1  pop address FIFO; data is valid the next cycle.
REQ-006 SHALL have port addr_fifo_rd_data  input  29  burst address {1'b1, pod, channel[2:0], ptr[21:0], 2'b0}.
REQ-007 SHALL have port data_fifo_rd_size  input  9  256-bit words available in the data FIFO.
REQ-008 SHALL have port data_fifo_rd_en  output  1  pop data FIFO; data is valid the next cycle.
REQ-009 SHALL have port data_fifo_rd_data  input  256  sample data word.
REQ-010 SHALL have ports app_en (output, 1), app_cmd (output, 3), app_addr (output, 29) and app_rdy (input, 1), forming the DRAM command handshake.
REQ-011 SHALL have ports app_wdf_wren (output, 1), app_wdf_data (output, 256), app_wdf_end (output, 1), app_wdf_mask (output, 32) and app_wdf_rdy (input, 1), forming the DRAM write-data handshake.
REQ-012 SHALL have port idle  output  1  high only in state IDLE.
REQ-013 SHALL have port burst_count  output  32  count of completed bursts.
REQ-014 SHALL have port stall_err  output  1  sticky stall flag.

Function
REQ-015 SHALL implement states IDLE, FETCH0, FETCH1 and ISSUE; each burst is one address plus two 256-bit beats.
REQ-016 In IDLE, when addr_fifo_empty=0 and data_fifo_rd_size>=2, SHALL pulse addr_fifo_rd_en and data_fifo_rd_en for one cycle, then go to FETCH0; otherwise SHALL remain in IDLE.
REQ-017 In FETCH0, SHALL latch addr_fifo_rd_data and data word 0, pulse data_fifo_rd_en once, then go to FETCH1.
REQ-018 In FETCH1, SHALL latch data word 1, then go to ISSUE.
REQ-019 In ISSUE, SHALL hold app_en=1, app_cmd=3'b000 and app_addr=latched address until the first cycle with app_rdy=1 (command accepted), then drive app_en=0.
REQ-020 In ISSUE, independently of the command handshake, SHALL present beat 0 (app_wdf_end=0) with app_wdf_wren=1 until app_wdf_rdy=1, then present beat 1 (app_wdf_end=1) until app_wdf_rdy=1.
REQ-021 Beats SHALL be sent in pop order; data SHALL NOT be reordered or modified.
REQ-022 Command acceptance and beat acceptance SHALL be allowed in the same cycle.
REQ-023 SHALL leave ISSUE for IDLE on the cycle after both the command and beat 1 are accepted, and SHALL increment burst_count by 1 on that transition, wrapping modulo 2^32.
REQ-024 app_wdf_mask SHALL be 0 at all times.
REQ-025 app_en and app_wdf_wren SHALL be 0 outside ISSUE; FIFO read enables SHALL be 0 outside IDLE and FETCH0.
REQ-026 SHALL NOT pop a FIFO when it is empty or holds insufficient data; one burst SHALL consume exactly one address and two data words.
REQ-027 Stall counter: SHALL clear on entry to ISSUE, increment on each ISSUE cycle without completion, and saturate at STALL_LIMIT.
REQ-028 When the stall counter reaches STALL_LIMIT, SHALL set stall_err and keep it set until reset; the handshakes SHALL continue normally.
REQ-029 All outputs SHALL be driven from registers or from state decode only, with no combinational path from app_rdy or app_wdf_rdy to app_en or app_wdf_wren.

Reset
REQ-030 While rst_n=0, SHALL immediately force state=IDLE, idle=1, all enables=0, app_wdf_end=0, app_addr=0, app_wdf_data=0, app_cmd=0, burst_count=0, stall_err=0 and stall counter=0.
REQ-031 If reset occurs mid-burst, already-popped words SHALL be discarded, and after release the block SHALL resume from IDLE with no partial command or beat issued.

Verification
REQ-032 Single burst: address 0x1200_0004, words A then B, app_rdy=app_wdf_rdy=1 -> app_en for 1 cycle with app_addr=0x1200_0004; beats A (end=0) then B (end=1); burst_count=1; 4 cycles from IDLE pop back to idle.
REQ-033 Insufficient data: addr_fifo_empty=0, data_fifo_rd_size=1 for 50 cycles -> no pops and idle=1; raising rd_size to 2 -> pop on the next edge.
REQ-034 Backpressure: app_rdy held low 5 cycles, app_wdf_rdy toggling 1010 -> app_en held for 6 cycles, beats unchanged until accepted, exactly one app_wdf_end beat, burst_count=1.
REQ-035 Stall: STALL_LIMIT=8, app_rdy=0 indefinitely -> stall_err=1 after 8 ISSUE cycles and stays 1; releasing app_rdy completes the burst and stall_err remains 1.
REQ-036 Reset mid-ISSUE: rst_n low after beat 0 is accepted -> all outputs reach reset values with no clock edge; after release, the next burst is issued cleanly and burst_count restarts from 0.
REQ-037 Back-to-back: 3 addresses and 6 words queued -> 3 bursts in order, burst_count=3, exactly 3 address pops and 6 data pops.
